// File: rtl/sa_os_tile.sv
// Output-stationary systolic MAC tile: skewed operand injection, K-deep accumulation,
// then one C row per handshake. States: IDLE wait start | LOAD accept K vectors |
// FLUSH let the wavefront drain | DRAIN emit rows 0..ROWS-1.
module sa_os_tile #(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int WIDTH  = 8,
  parameter  int ACC_W  = 2*WIDTH+8,
  parameter  int KLEN_W = 8,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [KLEN_W-1:0]       k_len,
  input  logic [ROWS*WIDTH-1:0]   a_in,
  input  logic [COLS*WIDTH-1:0]   b_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [ROW_W-1:0]        out_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  localparam int FLUSH_N = ROWS + COLS - 1;
  localparam int FL_W    = $clog2(FLUSH_N + 1);
  localparam int CNT_W   = (KLEN_W > FL_W) ? KLEN_W : FL_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   rd_q, rd_d;

  logic                       clr;
  logic                       inj_v;
  logic [ROWS*WIDTH-1:0]      inj_a;
  logic [COLS*WIDTH-1:0]      inj_b;

  // Link (r,c) is the operand arriving at PE(r,c); edge links come from the skew chains.
  logic [ROWS*COLS*WIDTH-1:0] a_link;
  logic [ROWS*COLS-1:0]       at_link;
  logic [ROWS*COLS*WIDTH-1:0] b_link;
  logic [ROWS*COLS*ACC_W-1:0] acc_flat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: begin
        rd_d = '0;
        if (start) begin
          if (k_len == '0) begin
            state_d = S_FLUSH;
            cnt_d   = CNT_W'(FLUSH_N - 1);
          end else begin
            state_d = S_LOAD;
            cnt_d   = CNT_W'(k_len);
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FLUSH;
            cnt_d   = CNT_W'(FLUSH_N - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_q == ROW_W'(ROWS - 1)) begin
            state_d = S_IDLE;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + ROW_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign busy      = (state_q != S_IDLE);
  assign out_row   = rd_q;
  assign out_last  = out_valid && (rd_q == ROW_W'(ROWS - 1));

  assign clr   = (state_q == S_IDLE) && start;
  assign inj_v = in_ready && in_valid;
  assign inj_a = inj_v ? a_in : '0;
  assign inj_b = inj_v ? b_in : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
    if (r == 0) begin : g_direct
      assign a_link[0 +: WIDTH] = inj_a[0 +: WIDTH];
      assign at_link[0]         = inj_v;
    end else begin : g_delay
      logic [WIDTH-1:0] d_q [r];
      logic [r-1:0]     t_q;
      always_ff @(posedge CLK) begin
        if (RST || clr) begin
          for (int i = 0; i < r; i++) d_q[i] <= '0;
          t_q <= '0;
        end else begin
          d_q[0] <= inj_a[r*WIDTH +: WIDTH];
          t_q[0] <= inj_v;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            t_q[i] <= t_q[i-1];
          end
        end
      end
      assign a_link[r*COLS*WIDTH +: WIDTH] = d_q[r-1];
      assign at_link[r*COLS]               = t_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_skew_b
    if (c == 0) begin : g_direct
      assign b_link[0 +: WIDTH] = inj_b[0 +: WIDTH];
    end else begin : g_delay
      logic [WIDTH-1:0] d_q [c];
      always_ff @(posedge CLK) begin
        if (RST || clr) begin
          for (int i = 0; i < c; i++) d_q[i] <= '0;
        end else begin
          d_q[0] <= inj_b[c*WIDTH +: WIDTH];
          for (int i = 1; i < c; i++) d_q[i] <= d_q[i-1];
        end
      end
      assign b_link[c*WIDTH +: WIDTH] = d_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      localparam int IDX = r*COLS + c;
      logic signed [WIDTH-1:0]   a_l, b_t;
      logic signed [2*WIDTH-1:0] prod;
      logic signed [ACC_W-1:0]   acc_q;

      assign a_l  = a_link[IDX*WIDTH +: WIDTH];
      assign b_t  = b_link[IDX*WIDTH +: WIDTH];
      assign prod = a_l * b_t;

      // The A tag governs; B tags are aligned by construction and not carried.
      always_ff @(posedge CLK) begin
        if (RST || clr)       acc_q <= '0;
        else if (at_link[IDX]) acc_q <= acc_q + ACC_W'(prod);
      end
      assign acc_flat[IDX*ACC_W +: ACC_W] = acc_q;

      if (c < COLS-1) begin : g_right
        logic [WIDTH-1:0] a_q;
        logic             t_q;
        always_ff @(posedge CLK) begin
          if (RST || clr) begin
            a_q <= '0;
            t_q <= 1'b0;
          end else begin
            a_q <= a_l;
            t_q <= at_link[IDX];
          end
        end
        assign a_link[(IDX+1)*WIDTH +: WIDTH] = a_q;
        assign at_link[IDX+1]                 = t_q;
      end

      if (r < ROWS-1) begin : g_down
        logic [WIDTH-1:0] b_q;
        always_ff @(posedge CLK) begin
          if (RST || clr) b_q <= '0;
          else            b_q <= b_t;
        end
        assign b_link[(IDX+COLS)*WIDTH +: WIDTH] = b_q;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < COLS; c++)
        out_data[c*ACC_W +: ACC_W] = acc_flat[(int'(rd_q)*COLS + c)*ACC_W +: ACC_W];
    end
  end

endmodule

// File: tb/tb_sa_os_tile.sv
// Scoreboard bench for sa_os_tile: a plain matrix-product model fills expected rows,
// monitors pop them on each output handshake.
module tb_sa_os_tile;
  localparam int ROWS = 4, COLS = 4, WIDTH = 8, ACC_W = 24, A16 = 16, KW = 8, RW = 2;

  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, start16 = 1'b0;
  logic [KW-1:0]         k_len = '0;
  logic [ROWS*WIDTH-1:0] a_in = '0;
  logic [COLS*WIDTH-1:0] b_in = '0;
  logic                  in_valid = 1'b0, out_ready = 1'b0;

  logic                  in_ready, out_valid, out_last, busy;
  logic [COLS*ACC_W-1:0] out_data;
  logic [RW-1:0]         out_row;
  logic                  in_ready16, out_valid16, out_last16, busy16;
  logic [COLS*A16-1:0]   out_data16;
  logic [RW-1:0]         out_row16;

  sa_os_tile #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ACC_W(ACC_W), .KLEN_W(KW)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy));

  sa_os_tile #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .ACC_W(A16), .KLEN_W(KW)) u_dut16 (
    .CLK(CLK), .RST(RST), .start(start16), .k_len(k_len), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready16), .out_data(out_data16), .out_row(out_row16),
    .out_valid(out_valid16), .out_ready(out_ready), .out_last(out_last16), .busy(busy16));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [COLS*ACC_W-1:0] d;
    logic [RW-1:0]         row;
    logic                  last;
  } exp_t;

  exp_t                q[$];
  logic [COLS*A16-1:0] q16[$];
  int am [ROWS][256];
  int bm [256][COLS];
  int errors = 0, checks = 0;
  int first_valid_cyc = -1, last_hs_cyc = 0;
  logic signed [A16-1:0] last16_l0 = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint cval(input int r, input int c, input int k);
    longint s = 0;
    for (int i = 0; i < k; i++) s += longint'(am[r][i]) * longint'(bm[i][c]);
    return s;
  endfunction

  task automatic push_exp(input int k);
    for (int r = 0; r < ROWS; r++) begin
      exp_t e;
      for (int c = 0; c < COLS; c++) begin
        longint v;
        v = cval(r, c, k);
        e.d[c*ACC_W +: ACC_W] = v[ACC_W-1:0];
      end
      e.row  = RW'(r);
      e.last = (r == ROWS-1);
      q.push_back(e);
    end
  endtask

  task automatic fill_rand(input int k);
    for (int i = 0; i < k; i++) begin
      for (int r = 0; r < ROWS; r++) am[r][i] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) bm[i][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic drive_vec(input int i);
    int t;
    for (int r = 0; r < ROWS; r++) begin t = am[r][i]; a_in[r*WIDTH +: WIDTH] = t[WIDTH-1:0]; end
    for (int c = 0; c < COLS; c++) begin t = bm[i][c]; b_in[c*WIDTH +: WIDTH] = t[WIDTH-1:0]; end
  endtask

  task automatic drive_garbage();
    a_in = $urandom;
    b_in = $urandom;
  endtask

  always @(negedge CLK) begin
    if (!RST && out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_row: row %0d presented with empty scoreboard", out_row);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("row_data", out_data, e.d);
          chk("row_index", out_row, e.row);
          chk("row_last", out_last, e.last);
          if (out_last) last_hs_cyc = cyc;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && out_valid16 && out_ready) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row16: row %0d presented with empty scoreboard", out_row16);
      end else begin
        chk("row16_data", out_data16, q16.pop_front());
        last16_l0 = out_data16[0 +: A16];
      end
    end
  end

  task automatic start_job(input int k, output int s);
    s     = cyc;
    start = 1'b1;
    k_len = KW'(k);
    @(posedge CLK); #1;
    start = 1'b0;
    k_len = KW'($urandom);
    chk("busy_after_start", busy, 1'b1);
    chk("in_ready_after_start", in_ready, k > 0);
  endtask

  task automatic run_job(input int k, input bit bub, input bit bp, input bit tim);
    int s, n, g;
    bit v, ir_seen;
    logic [3:0] pat;
    logic [COLS*ACC_W-1:0] hold;
    logic [RW-1:0] hrow;
    push_exp(k);
    out_ready = !bp;
    first_valid_cyc = -1;
    ir_seen = 1'b0;
    pat = 4'b1001;
    start_job(k, s);
    n = 0;
    g = 0;
    while (n < k && g < 5000) begin
      v = bub ? ((g < 4) ? pat[3-g] : 1'($urandom_range(0, 1))) : 1'b1;
      if (v) drive_vec(n); else drive_garbage();
      in_valid = v;
      @(posedge CLK); #1;
      if (v) n++;
      g++;
    end
    chk("feed_count", n, k);
    if (bub) begin in_valid = 1'b1; drive_garbage(); end
    else in_valid = 1'b0;
    if (bp) begin
      for (int r = 0; r < ROWS; r++) begin
        g = 0;
        while (!out_valid && g < 2000) begin
          @(posedge CLK); #1;
          g++;
          if (bub) drive_garbage();
        end
        chk("drain_wait", out_valid, 1'b1);
        hold = out_data;
        hrow = out_row;
        repeat (2) begin
          @(posedge CLK); #1;
          drive_garbage();
          chk("bp_data_stable", out_data, hold);
          chk("bp_row_stable", out_row, hrow);
          chk("bp_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        out_ready = 1'b0;
      end
    end
    g = 0;
    while (busy && g < 2000) begin
      ir_seen |= in_ready;
      @(posedge CLK); #1;
      g++;
    end
    chk("busy_fall", busy, 1'b0);
    in_valid = 1'b0;
    if (tim) begin
      chk("first_out_valid_cycle", first_valid_cyc - s, k + ROWS + COLS);
      chk("busy_fall_cycle", cyc - last_hs_cyc, 1);
    end
    if (k == 0) chk("k0_in_ready_seen", ir_seen, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, g;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_row", out_row, '0);
    chk("rst_out_data", out_data, '0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // A = identity, B[k][c] = 4k+c: rows come out equal to B rows.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < ROWS; r++) am[r][i] = (r == i) ? 1 : 0;
      for (int c = 0; c < COLS; c++) bm[i][c] = i*4 + c;
    end
    run_job(4, 1'b0, 1'b0, 1'b1);

    // Back-to-back start in the first IDLE cycle, signed extremes.
    for (int i = 0; i < 200; i++) begin
      for (int r = 0; r < ROWS; r++) am[r][i] = -128;
      for (int c = 0; c < COLS; c++) bm[i][c] = -128;
    end
    run_job(200, 1'b0, 1'b0, 1'b1);

    // 16-bit accumulator wrap on the second instance.
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < ROWS; r++) am[r][i] = 127;
      for (int c = 0; c < COLS; c++) bm[i][c] = 127;
    end
    for (int r = 0; r < ROWS; r++) begin
      logic [COLS*A16-1:0] d16;
      for (int c = 0; c < COLS; c++) begin
        longint v;
        v = cval(r, c, 3);
        d16[c*A16 +: A16] = v[A16-1:0];
      end
      q16.push_back(d16);
    end
    out_ready = 1'b1;
    start16 = 1'b1;
    k_len = 8'd3;
    @(posedge CLK); #1;
    start16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_vec(i);
      in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    g = 0;
    while (busy16 && g < 2000) begin @(posedge CLK); #1; g++; end
    chk("busy16_fall", busy16, 1'b0);
    chk("ovf_signed", int'(last16_l0), -17149);

    // Random operands, bubbles, garbage in_valid after LOAD, 3-cycle backpressure.
    fill_rand(7);
    run_job(7, 1'b1, 1'b1, 1'b0);
    fill_rand(1);
    run_job(1, 1'b1, 1'b1, 1'b0);
    fill_rand(13);
    run_job(13, 1'b1, 1'b1, 1'b0);

    run_job(0, 1'b0, 1'b0, 1'b1);

    // Abort a job with a reset pulse midway through LOAD.
    fill_rand(5);
    out_ready = 1'b1;
    start_job(5, s);
    for (int i = 0; i < 2; i++) begin
      drive_vec(i);
      in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    in_valid = 1'b0;
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_last", out_last, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_row", out_row, '0);
    chk("abort_out_data", out_data, '0);
    @(posedge CLK); #1;
    fill_rand(2);
    run_job(2, 1'b0, 1'b0, 1'b1);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_left", q.size(), 0);
    chk("scoreboard16_left", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
